sine_freq_meter: RTL and testbench

Receive-side companion to the DDS sine/cosine generator. It consumes a stream of signed sine samples and measures the tone's frequency tuning word over a window of 2^ACC_W valid samples. Frequency is measured by counting rising zero crossings with hysteresis. Because f_out/f_clk = M/2^ACC_W, the crossing count over the window equals M directly. It also reports peak absolute amplitude and returns results through a valid/ready handshake. Used for DDS loopback self-test and for tone measurement on ADC streams.

---
 rtl/sine_meter_pkg.sv | 33 +++
 rtl/sine_freq_meter_if.sv | 31 +++
 rtl/zero_cross_det.sv | 41 ++++
 rtl/sine_freq_meter.sv | 115 +++++++++++
 tb/tb_sine_freq_meter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/sine_meter_pkg.sv
// Shared definitions for the sine frequency meter and its DDS companion.
// Holds the default widths (so generator and meter agree), the FSM state
// encoding and a saturating absolute-value helper.
package sine_meter_pkg;

    // Defaults shared with the DDS generator.
    localparam int unsigned DATA_W_DEF = 14;
    localparam int unsigned ACC_W_DEF  = 12;
    localparam int unsigned HYST_DEF   = 64;

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StDone
    } meter_state_e;

    // |x| for a w-bit signed value carried sign-extended in 32 bits. The most
    // negative w-bit value has no positive counterpart and saturates to
    // 2^(w-1)-1 so the result always fits in w-1 bits.
    function automatic logic [31:0] abs_sat(input logic signed [31:0] x,
                                            input int unsigned w);
        logic signed [31:0] min_v;
        min_v = -(32'sd1 <<< (w - 1));
        if (x == min_v) begin
            return (32'd1 << (w - 1)) - 32'd1;
        end else if (x < 0) begin
            return -x;
        end else begin
            return x;
        end
    endfunction

endpackage

// File: rtl/sine_freq_meter_if.sv
// Sample-stream and result-handshake bundle for sine_freq_meter.
//   in_valid/in_sample : signed sample stream into the meter
//   start/busy         : measurement control and status
//   m_est/peak         : last completed window's crossing count and peak |x|
//   out_valid/out_ready: result handshake
// master drives the stream and consumes results; slave is the meter.
interface sine_freq_meter_if
    import sine_meter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_sample;
    logic                     start;
    logic                     busy;
    logic [ACC_W:0]           m_est;
    logic [DATA_W-2:0]        peak;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_valid, in_sample, start, out_ready,
        input  busy, m_est, peak, out_valid
    );

    modport slave (
        input  in_valid, in_sample, start, out_ready,
        output busy, m_est, peak, out_valid
    );
endinterface

// File: rtl/zero_cross_det.sv
// Rising zero-crossing detector with hysteresis.
//   clk, rst  : clock, synchronous active-low reset
//   in_valid  : in_sample is valid this cycle; invalid cycles are ignored
//   in_sample : signed input sample
//   cross_evt : combinational pulse, high when the current valid sample
//               completes a crossing (armed and sample >= +HYST)
// A sample below -HYST arms the detector; the next sample at or above +HYST
// fires and disarms. Samples inside the dead band leave the state alone.
module zero_cross_det
    import sine_meter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned HYST   = HYST_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_sample,
    output logic                     cross_evt
);

    localparam logic signed [DATA_W-1:0] HiThr = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] LoThr = -HiThr;

    logic armed;

    assign cross_evt = in_valid && armed && (in_sample >= HiThr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            armed <= 1'b0;
        end else if (in_valid) begin
            if (in_sample < LoThr) begin
                armed <= 1'b1;
            end else if (cross_evt) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sine_freq_meter.sv
// Tone frequency / amplitude meter for a signed sine sample stream.
// Counts rising zero crossings over 2^ACC_W valid samples; since
// f_out/f_clk = M/2^ACC_W the count equals the DDS tuning word M. Also
// tracks the peak |sample| over the window.
//   clk, rst : clock, synchronous active-low reset
//   bus      : sine_freq_meter_if slave (stream in, start/busy, results out)
// Results are held stable from out_valid until accepted and keep their value
// afterwards until the next window completes.
module sine_freq_meter
    import sine_meter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned HYST   = HYST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    sine_freq_meter_if.slave  bus
);

    meter_state_e      state;
    logic [ACC_W-1:0]  win_cnt;
    logic [ACC_W:0]    cross_cnt;
    logic [ACC_W:0]    cross_nxt;
    logic [DATA_W-2:0] peak_acc;
    logic [DATA_W-2:0] peak_nxt;
    logic [DATA_W-2:0] sample_abs;
    logic [31:0]       abs_full;
    logic              unused_abs_hi;
    logic              cross_evt;

    logic              busy_q;
    logic              out_valid_q;
    logic [ACC_W:0]    m_est_q;
    logic [DATA_W-2:0] peak_q;

    // Detector runs in every state so the armed flag carries across windows.
    zero_cross_det #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_zcd (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_sample (bus.in_sample),
        .cross_evt (cross_evt)
    );

    always_comb begin
        abs_full   = abs_sat(32'(signed'(bus.in_sample)), DATA_W);
        sample_abs = abs_full[DATA_W-2:0];
        cross_nxt  = cross_cnt + (ACC_W + 1)'(cross_evt);
        peak_nxt   = (sample_abs > peak_acc) ? sample_abs : peak_acc;
    end

    // abs_sat never produces more than DATA_W-1 significant bits.
    assign unused_abs_hi = ^abs_full[31:DATA_W-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= StIdle;
            win_cnt     <= '0;
            cross_cnt   <= '0;
            peak_acc    <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            m_est_q     <= '0;
            peak_q      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (bus.start) begin
                        state     <= StMeasure;
                        busy_q    <= 1'b1;
                        win_cnt   <= '0;
                        cross_cnt <= '0;
                        peak_acc  <= '0;
                    end
                end
                StMeasure: begin
                    if (bus.in_valid) begin
                        win_cnt   <= win_cnt + ACC_W'(1);
                        cross_cnt <= cross_nxt;
                        peak_acc  <= peak_nxt;
                        // Last sample of the window: publish including its
                        // own contribution.
                        if (win_cnt == '1) begin
                            state       <= StDone;
                            out_valid_q <= 1'b1;
                            m_est_q     <= cross_nxt;
                            peak_q      <= peak_nxt;
                        end
                    end
                end
                StDone: begin
                    // start is ignored here, even alongside out_ready.
                    if (bus.out_ready) begin
                        state       <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.m_est     = m_est_q;
    assign bus.peak      = peak_q;

endmodule

// File: tb/tb_sine_freq_meter.sv
// Directed bench for sine_freq_meter: DDS-style tones, handshake hold,
// mid-window reset and hysteresis dead band.
module tb_sine_freq_meter;
    import sine_meter_pkg::*;

    localparam int unsigned DW = 14;
    localparam int unsigned AW = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sine_freq_meter_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

    sine_freq_meter #(
        .DATA_W (DW),
        .ACC_W  (AW),
        .HYST   (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Ideal DDS sine sample, amplitude 8191, rounded to nearest.
    function automatic logic signed [13:0] dds(input int phase);
        real x;
        x = 8191.0 * $sin(2.0 * 3.14159265358979323846 * real'(phase) / 4096.0);
        if (x >= 0.0) return 14'($rtoi(x + 0.5));
        else return 14'($rtoi(x - 0.5));
    endfunction

    // mode 0: DDS tone; mode 1: +/-63 dead-band pattern with one -8192 at
    // window sample 1000.
    function automatic logic signed [13:0] gen(input int mode, input int phase, input int idx);
        if (mode == 0) return dds(phase);
        if (idx == 1000) return 14'sh2000;
        return (idx % 2 != 0) ? -14'sd63 : 14'sd63;
    endfunction

    task automatic step(input logic v, input logic signed [13:0] s);
        bus.in_valid  = v;
        bus.in_sample = s;
        @(posedge clk);
        #1;
    endtask

    // Pre-roll one full window so the detector sees the tone, then start and
    // run until out_valid. lat counts edges from the start edge inclusive.
    task automatic measure(input int mode, input int m, input int p0, input bit toggle,
                           output int lat);
        int phase;
        int idx;
        bit v;
        phase = p0;
        for (int i = 0; i < 4096; i++) begin
            step(1'b1, gen(mode, phase, 4096 + i));
            phase = (phase + m) % 4096;
        end
        bus.start = 1'b1;
        step(1'b1, gen(mode, phase, 9000));
        phase = (phase + m) % 4096;
        bus.start = 1'b0;
        lat = 1;
        idx = 0;
        v = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 20000) begin
            if (v) begin
                step(1'b1, gen(mode, phase, idx));
                phase = (phase + m) % 4096;
                idx++;
            end else begin
                step(1'b0, 14'sh2000);
            end
            if (toggle) v = ~v;
            lat++;
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        step(1'b1, '0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int phase;
        bus.in_valid  = 1'b0;
        bus.in_sample = '0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        repeat (3) step(1'b0, '0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_m_est", 32'(bus.m_est), 32'd0);
        check("rst_peak", 32'(bus.peak), 32'd0);
        rst = 1'b1;

        // Tuning word 64, arbitrary start phase.
        measure(0, 64, (37 * 64) % 4096, 1'b0, lat);
        check("m64_latency", 32'(lat), 32'd4097);
        check("m64_m_est", 32'(bus.m_est), 32'd64);
        check("m64_peak", 32'(bus.peak), 32'd8191);
        check("m64_busy", 32'(bus.busy), 32'd1);

        // Back-pressure in DONE with a stray start pulse.
        for (int i = 0; i < 10; i++) begin
            bus.start = (i == 4);
            step(1'b1, dds(i * 300));
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_m_est", 32'(bus.m_est), 32'd64);
            check("hold_busy", 32'(bus.busy), 32'd1);
        end
        bus.start = 1'b0;
        accept();
        check("acc_out_valid", 32'(bus.out_valid), 32'd0);
        check("acc_busy", 32'(bus.busy), 32'd0);
        check("acc_m_est_kept", 32'(bus.m_est), 32'd64);
        check("acc_peak_kept", 32'(bus.peak), 32'd8191);
        repeat (3) step(1'b1, '0);
        check("start_not_queued", 32'(bus.busy), 32'd0);

        // Tuning word 1024: 0, 8191, 0, -8191 repeating.
        measure(0, 1024, 1024, 1'b0, lat);
        check("m1024_m_est", 32'(bus.m_est), 32'd1024);
        check("m1024_latency", 32'(lat), 32'd4097);
        accept();

        // Tuning word 1: one period per window.
        measure(0, 1, 1234, 1'b0, lat);
        check("m1_m_est", 32'(bus.m_est), 32'd1);
        check("m1_peak", 32'(bus.peak), 32'd8191);
        accept();

        // Tuning word 256 with in_valid alternating; invalid cycles carry -8192.
        measure(0, 256, (37 * 256) % 4096, 1'b1, lat);
        check("m256_latency", 32'(lat), 32'd8192);
        check("m256_m_est", 32'(bus.m_est), 32'd256);
        check("m256_peak", 32'(bus.peak), 32'd8191);
        accept();

        // Reset on window sample 2000.
        phase = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, dds(phase));
            phase = (phase + 64) % 4096;
        end
        bus.start = 1'b1;
        step(1'b1, dds(phase));
        phase = (phase + 64) % 4096;
        bus.start = 1'b0;
        for (int i = 1; i < 2000; i++) begin
            step(1'b1, dds(phase));
            phase = (phase + 64) % 4096;
        end
        rst = 1'b0;
        step(1'b1, dds(phase));
        check("mid_rst_m_est", 32'(bus.m_est), 32'd0);
        check("mid_rst_peak", 32'(bus.peak), 32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        repeat (5) step(1'b1, '0);
        check("mid_rst_idle", 32'(bus.busy), 32'd0);
        measure(0, 64, 640, 1'b0, lat);
        check("post_rst_m_est", 32'(bus.m_est), 32'd64);
        accept();

        // Dead band: +/-63 never fires; -8192 saturates the peak.
        measure(1, 0, 0, 1'b0, lat);
        check("hyst_latency", 32'(lat), 32'd4097);
        check("hyst_m_est", 32'(bus.m_est), 32'd0);
        check("hyst_peak", 32'(bus.peak), 32'd8191);

        // start coinciding with the accepting handshake is dropped.
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        step(1'b1, '0);
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check("both_out_valid", 32'(bus.out_valid), 32'd0);
        check("both_busy", 32'(bus.busy), 32'd0);
        step(1'b1, '0);
        check("both_start_dropped", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
